// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

    // Transfer sequencing: idle, counting wait states, presenting the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    // PSLVERR encodings.
    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    // Value returned by a read of register 0 unless overridden.
    localparam logic [31:0] APB_DEFAULT_ID = 32'hA5B0_0001;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB3 bus bundle between the AHB-to-APB bridge (master) and this completer.
//
// Handshake: a transfer opens with one setup cycle (PSEL=1, PENABLE=0) and
// continues with access cycles (PSEL=1, PENABLE=1). It completes on the rising
// edge at which PSEL, PENABLE and PREADY are all 1; PRDATA and PSLVERR carry
// meaning only in that cycle. Dropping PSEL before completion abandons it.
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_slave_addr_decode.sv
// Combinational address decode: byte address -> register index and error flag.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_W      = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  write,
    output logic [IDX_W-1:0]      idx,
    output logic                  err
);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * 4);

    logic [ADDR_WIDTH-1:0] off;

    // Below-base, beyond-window, misaligned and ID-register writes all fail.
    always_comb begin
        off = paddr - BASE_ADDR;
        idx = off[2 +: IDX_W];
        err = (paddr < BASE_ADDR)
           || (off >= SPAN)
           || (paddr[1:0] != 2'b00)
           || (write && (idx == '0));
    end
endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer holding NUM_REGS 32-bit registers; register 0 is a read-only ID.
// Every transfer is stretched by WAIT_STATES access cycles with PREADY low.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(APB_DEFAULT_ID)
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    apb_regfile_slave_if.slave             apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o,
    output apb_state_e                     state_o
);
    localparam int                IDX_W    = $clog2(NUM_REGS);
    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  commit;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [IDX_W-1:0]      rsp_idx;
    logic                  rsp_err;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rd_val;

    // Register 0 is the constant ID, so only 1..NUM_REGS-1 are storage.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_decode (
        .paddr (apb.PADDR),
        .write (apb.PWRITE),
        .idx   (dec_idx),
        .err   (dec_err)
    );

    // With no wait states the response is built from the live setup decode,
    // otherwise from the copies latched at setup.
    always_comb begin
        if (state_q == IDLE) begin
            rsp_idx   = dec_idx;
            rsp_err   = dec_err;
            rsp_write = apb.PWRITE;
        end else begin
            rsp_idx   = idx_q;
            rsp_err   = err_q;
            rsp_write = write_q;
        end
    end

    // Read mux over the ID constant and the storage registers.
    always_comb begin
        rd_val = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rsp_idx == IDX_W'(i)) rd_val = regs_q[i];
        end
    end

    // Next-state and next-output logic; outputs fall to zero unless a state sets them.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        prdata_d   = '0;
        pready_d   = 1'b0;
        pslverr_d  = APB_OKAY;
        wr_pulse_d = '0;
        commit     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
                    if (WAIT_STATES == 0) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = rsp_err ? APB_ERR : APB_OKAY;
                        prdata_d  = (!rsp_write && !rsp_err) ? rd_val : '0;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = rsp_err ? APB_ERR : APB_OKAY;
                    prdata_d  = (!rsp_write && !rsp_err) ? rd_val : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;
                end else if (apb.PENABLE) begin
                    state_d = IDLE;
                    if (write_q && !err_q) begin
                        commit              = 1'b1;
                        wr_pulse_d[idx_q]   = 1'b1;
                    end
                end else begin
                    // Response held until the master completes the access.
                    pready_d  = pready_q;
                    pslverr_d = pslverr_q;
                    prdata_d  = prdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched transfer and registered bus outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= APB_OKAY;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Register array; reset wins over a commit at the same edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit && (idx_q == IDX_W'(i))) regs_q[i] <= wdata_q;
            end
        end
    end

    // Flat view of the register file with the ID in slot 0.
    always_comb begin
        regs_o = '0;
        regs_o[0 +: DATA_WIDTH] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign wr_pulse_o  = wr_pulse_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: one instance with no wait states and
// one with three, sharing a single APB master steered by tgt.
module tb_apb_regfile_slave;
    import apb_pkg::*;

    localparam int          NR  = 16;
    localparam int          WS0 = 0;
    localparam int          WS1 = 3;
    localparam logic [31:0] ID  = 32'hA5B0_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared master drive ----------------
    logic        tgt = 1'b0;
    logic        m_psel = 1'b0;
    logic        m_penable = 1'b0;
    logic        m_pwrite = 1'b0;
    logic [31:0] m_paddr = '0;
    logic [31:0] m_pwdata = '0;

    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.PSEL    = m_psel & ~tgt;
    assign bus0.PENABLE = m_penable & ~tgt;
    assign bus0.PADDR   = m_paddr;
    assign bus0.PWRITE  = m_pwrite;
    assign bus0.PWDATA  = m_pwdata;
    assign bus1.PSEL    = m_psel & tgt;
    assign bus1.PENABLE = m_penable & tgt;
    assign bus1.PADDR   = m_paddr;
    assign bus1.PWRITE  = m_pwrite;
    assign bus1.PWDATA  = m_pwdata;

    logic [NR*32-1:0] regs0, regs1;
    logic [NR-1:0]    pulse0, pulse1;
    apb_state_e       st0, st1;

    apb_regfile_slave #(.WAIT_STATES(WS0)) dut0 (
        .PCLK(clk), .PRESET(rst), .apb(bus0.slave),
        .regs_o(regs0), .wr_pulse_o(pulse0), .state_o(st0)
    );

    apb_regfile_slave #(.WAIT_STATES(WS1)) dut1 (
        .PCLK(clk), .PRESET(rst), .apb(bus1.slave),
        .regs_o(regs1), .wr_pulse_o(pulse1), .state_o(st1)
    );

    // ---------------- reference model ----------------
    logic [31:0] model [2][NR];
    int n_checks = 0;
    int n_errors = 0;

    // Entry: {waits[3:0], err, pulse[15:0], rdata[31:0]}
    logic [52:0] exp_q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void reset_model();
        for (int d = 0; d < 2; d++) begin
            model[d][0] = ID;
            for (int i = 1; i < NR; i++) model[d][i] = '0;
        end
    endfunction

    function automatic logic [NR*32-1:0] flat(input int d);
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[d][i];
        return v;
    endfunction

    // A transfer is good when word aligned, inside the 16-word window and not
    // a write to the ID word.
    function automatic bit addr_ok(input logic [31:0] a, input bit wr);
        if (a % 4 != 0) return 1'b0;
        if (a >= NR * 4) return 1'b0;
        if (wr && (a / 4 == 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [52:0] predict(input int t, input bit wr, input logic [31:0] a);
        logic [3:0]  waits;
        logic        err;
        logic [15:0] pulse;
        logic [31:0] data;
        waits = (t == 0) ? 4'(WS0) : 4'(WS1);
        err   = !addr_ok(a, wr);
        pulse = '0;
        data  = '0;
        if (!err && wr)  pulse[a / 4] = 1'b1;
        if (!err && !wr) data = model[t][a / 4];
        return {waits, err, pulse, data};
    endfunction

    function automatic logic cur_rdy();
        return tgt ? bus1.PREADY : bus0.PREADY;
    endfunction

    // ---------------- driver ----------------
    // mode 0: normal; mode 1: drop PSEL after n access cycles; mode 2: reset in RESP.
    // Called at one time unit after a rising edge; returns the same way.
    task automatic xfer(input int t, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input int n);
        bit done;
        tgt       = (t != 0);
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_pwrite  = wr;
        m_paddr   = a;
        m_pwdata  = d;
        if (mode == 0) exp_q.push_back(predict(t, wr, a));
        @(posedge clk); #1;
        m_penable = 1'b1;
        m_paddr   = $urandom;
        m_pwdata  = $urandom;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mode == 1 && c == n) begin
                m_psel    = 1'b0;
                m_penable = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort_state_idle", (t != 0) ? st1 : st0, IDLE);
                check("abort_regs", (t != 0) ? regs1 : regs0, flat(t));
                @(posedge clk); #1;
                done = 1'b1;
            end else if (cur_rdy()) begin
                if (mode == 2) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst       = 1'b0;
                    m_psel    = 1'b0;
                    m_penable = 1'b0;
                    reset_model();
                    @(negedge clk);
                    check("rst_pready", bus1.PREADY, 1'b0);
                    check("rst_prdata", bus1.PRDATA, 32'h0);
                    check("rst_pslverr", bus1.PSLVERR, 1'b0);
                    check("rst_pulse", pulse1, 16'h0);
                    check("rst_regs1", regs1, flat(1));
                    check("rst_regs0", regs0, flat(0));
                    check("rst_state", st1, IDLE);
                    @(posedge clk); #1;
                end else begin
                    @(posedge clk); #1;
                    m_psel    = 1'b0;
                    m_penable = 1'b0;
                    if (wr && addr_ok(a, wr)) model[t][a / 4] = d;
                end
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            check("pready_timeout", 1'b0, 1'b1);
            m_psel    = 1'b0;
            m_penable = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          wcnt = 0;
    bit          pend = 1'b0;
    int          pend_t = 0;
    logic [15:0] pend_pulse = '0;

    always @(negedge clk) begin
        logic        c_sel, c_en, c_rdy, c_err;
        logic [31:0] c_rd;
        logic [52:0] e;
        if (rst) begin
            wcnt = 0;
            pend = 1'b0;
        end else begin
            check("wr_pulse0", pulse0, (pend && pend_t == 0) ? pend_pulse : 16'h0);
            check("wr_pulse1", pulse1, (pend && pend_t == 1) ? pend_pulse : 16'h0);
            if (pend) check("regs_after_xfer", (pend_t != 0) ? regs1 : regs0, flat(pend_t));
            pend = 1'b0;

            c_sel = tgt ? bus1.PSEL    : bus0.PSEL;
            c_en  = tgt ? bus1.PENABLE : bus0.PENABLE;
            c_rdy = tgt ? bus1.PREADY  : bus0.PREADY;
            c_err = tgt ? bus1.PSLVERR : bus0.PSLVERR;
            c_rd  = tgt ? bus1.PRDATA  : bus0.PRDATA;
            if (!c_sel) begin
                wcnt = 0;
            end else if (c_en && !c_rdy) begin
                wcnt++;
            end else if (c_en && c_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wait_cycles", 4'(wcnt), e[52:49]);
                    check("pslverr", c_err, e[48]);
                    check("prdata", c_rd, e[31:0]);
                    pend       = 1'b1;
                    pend_t     = tgt ? 1 : 0;
                    pend_pulse = e[47:32];
                end
                wcnt = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          t, r, mode, n;
        bit          wr;
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_pready0", bus0.PREADY, 1'b0);
        check("reset_prdata0", bus0.PRDATA, 32'h0);
        check("reset_pslverr0", bus0.PSLVERR, 1'b0);
        check("reset_pready1", bus1.PREADY, 1'b0);
        check("reset_regs0", regs0, flat(0));
        check("reset_regs1", regs1, flat(1));
        check("reset_state0", st0, IDLE);
        check("reset_state1", st1, IDLE);
        @(posedge clk); #1;

        // Zero-wait write then back-to-back read of the same word.
        xfer(0, 1'b1, 32'h04, 32'h1234_5678, 0, 0);
        xfer(0, 1'b0, 32'h04, 32'h0, 0, 0);
        // Three wait states on an ID read.
        xfer(1, 1'b0, 32'h00, 32'h0, 0, 0);
        // Writes to the ID fail and leave it intact.
        xfer(0, 1'b1, 32'h00, 32'hDEAD_BEEF, 0, 0);
        xfer(0, 1'b0, 32'h00, 32'h0, 0, 0);
        xfer(1, 1'b1, 32'h00, 32'hDEAD_BEEF, 0, 0);
        xfer(1, 1'b0, 32'h00, 32'h0, 0, 0);
        // Out-of-window and misaligned accesses.
        xfer(0, 1'b0, 32'h40, 32'h0, 0, 0);
        xfer(0, 1'b0, 32'h06, 32'h0, 0, 0);
        xfer(1, 1'b1, 32'h46, 32'h1, 0, 0);
        // Abort during wait states, then the same write completed.
        xfer(1, 1'b1, 32'h08, 32'h55, 1, 1);
        xfer(1, 1'b1, 32'h08, 32'h55, 0, 0);
        xfer(1, 1'b0, 32'h08, 32'h0, 0, 0);
        // Reset lands on the completing edge of a write.
        xfer(1, 1'b1, 32'h0C, 32'hFF, 2, 0);
        xfer(1, 1'b0, 32'h0C, 32'h0, 0, 0);
        xfer(0, 1'b0, 32'h04, 32'h0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            t  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 255));
            else             a = 32'h40 + 32'($urandom_range(0, 63)) * 4;
            mode = (t == 1 && $urandom_range(0, 9) == 0) ? 1 : 0;
            n    = $urandom_range(0, 2);
            xfer(t, wr, a, $urandom, mode, n);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
